// File: rtl/boot_copy_ctrl.sv
// Boot sequencer: copies the boot ROM image into instruction RAM over a
// req/gnt bus, then releases core fetch; a grant timeout parks it in ERR.
module boot_copy_ctrl #(
    parameter int unsigned ROM_WORDS      = 58,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROM_ADDR_WIDTH = 10,
    parameter int unsigned RAM_ADDR_WIDTH = 32,
    parameter logic [RAM_ADDR_WIDTH-1:0] RAM_BASE = '0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    output logic                      rom_en_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0]     rom_rdata_i,
    output logic                      ram_req_o,
    output logic                      ram_we_o,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    input  logic                      ram_gnt_i,
    input  logic                      restart_i,
    output logic                      boot_done_o,
    output logic                      boot_err_o,
    output logic                      fetch_en_o,
    output logic [ROM_ADDR_WIDTH:0]   words_copied_o
);

    localparam int unsigned BPW = DATA_WIDTH / 8;
    localparam int unsigned CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [ROM_ADDR_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [CW-1:0]             r_wait;
    logic [ROM_ADDR_WIDTH:0]   r_copied;
    logic                      w_last;
    logic                      w_expire;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;

    assign w_last   = (r_idx == ROM_ADDR_WIDTH'(ROM_WORDS - 1));
    assign w_expire = (TIMEOUT_CYCLES != 0) && (r_wait == TO_LAST);
    assign w_ram_addr = RAM_BASE
                      + RAM_ADDR_WIDTH'(r_idx) * RAM_ADDR_WIDTH'(BPW);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        rom_en_o       = 1'b0;
        rom_addr_o     = '0;
        ram_req_o      = 1'b0;
        ram_we_o       = 1'b0;
        ram_addr_o     = '0;
        ram_wdata_o    = '0;
        ram_be_o       = '0;
        boot_done_o    = 1'b0;
        boot_err_o     = 1'b0;
        fetch_en_o     = 1'b0;
        words_copied_o = r_copied;
        unique case (r_state)
            S_IDLE: w_next = S_READ;
            S_READ: begin
                rom_en_o   = 1'b1;
                rom_addr_o = r_idx;
                w_next     = S_WAIT;
            end
            S_WAIT: w_next = S_WRITE;
            S_WRITE: begin
                ram_req_o   = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = w_ram_addr;
                ram_wdata_o = r_wdata;
                ram_be_o    = '1;
                // a grant on the expiry cycle still wins over the timeout
                if (ram_gnt_i) begin
                    w_next = w_last ? S_DONE : S_READ;
                end else if (w_expire) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                boot_done_o = 1'b1;
                fetch_en_o  = 1'b1;
                if (restart_i) w_next = S_READ;
            end
            S_ERR: begin
                boot_err_o = 1'b1;
                if (restart_i) w_next = S_READ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_idx    <= '0;
            r_wdata  <= '0;
            r_wait   <= '0;
            r_copied <= '0;
        end else begin
            unique case (r_state)
                S_WAIT: begin
                    r_wdata <= rom_rdata_i;
                    r_wait  <= '0;
                end
                S_WRITE: begin
                    if (ram_gnt_i) begin
                        r_copied <= r_copied + 1'b1;
                        if (!w_last) r_idx <= r_idx + 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (restart_i) begin
                        r_idx    <= '0;
                        r_copied <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_copy_ctrl.sv
// Directed bench for boot_copy_ctrl: copy, stalls, timeout, restart,
// mid-copy reset, single-word offset base and default-size latency.
module tb_boot_copy_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // DUT1: 4 words, timeout 8
    logic        rst1_n, gnt1, restart1;
    logic        rom_en1, req1, we1, done1, err1, fetch1;
    logic [9:0]  rom_addr1;
    logic [31:0] rdata1, addr1, wdata1;
    logic [3:0]  be1;
    logic [10:0] copied1;

    boot_copy_ctrl #(.ROM_WORDS(4), .TIMEOUT_CYCLES(8)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst1_n),
        .rom_en_o(rom_en1), .rom_addr_o(rom_addr1), .rom_rdata_i(rdata1),
        .ram_req_o(req1), .ram_we_o(we1), .ram_addr_o(addr1),
        .ram_wdata_o(wdata1), .ram_be_o(be1), .ram_gnt_i(gnt1),
        .restart_i(restart1), .boot_done_o(done1), .boot_err_o(err1),
        .fetch_en_o(fetch1), .words_copied_o(copied1)
    );

    always @(posedge clk) if (rom_en1) rdata1 <= 32'hA0 + {22'b0, rom_addr1};

    logic [31:0] wa1[64];
    logic [31:0] wd1[64];
    logic [3:0]  wb1[64];
    int nw1 = 0, nre1 = 0, nst1 = 0, stab1 = 0;
    logic        pv_stall = 1'b0;
    logic [31:0] pv_a, pv_d;

    always @(posedge clk) begin
        if (req1 && gnt1 && nw1 < 64) begin
            wa1[nw1] <= addr1;
            wd1[nw1] <= wdata1;
            wb1[nw1] <= be1;
            nw1      <= nw1 + 1;
        end
        if (rom_en1) nre1 <= nre1 + 1;
        if (req1 && !gnt1) nst1 <= nst1 + 1;
        if (pv_stall && req1 && (addr1 !== pv_a || wdata1 !== pv_d))
            stab1 <= stab1 + 1;
        pv_stall <= req1 && !gnt1;
        pv_a     <= addr1;
        pv_d     <= wdata1;
    end

    // DUT2: single word at base 0x8000
    logic        rst2_n, gnt2, restart2;
    logic        rom_en2, req2, we2, done2, err2, fetch2;
    logic [9:0]  rom_addr2;
    logic [31:0] rdata2, addr2, wdata2;
    logic [3:0]  be2;
    logic [10:0] copied2;

    boot_copy_ctrl #(.ROM_WORDS(1), .RAM_BASE(32'h8000), .TIMEOUT_CYCLES(8)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst2_n),
        .rom_en_o(rom_en2), .rom_addr_o(rom_addr2), .rom_rdata_i(rdata2),
        .ram_req_o(req2), .ram_we_o(we2), .ram_addr_o(addr2),
        .ram_wdata_o(wdata2), .ram_be_o(be2), .ram_gnt_i(gnt2),
        .restart_i(restart2), .boot_done_o(done2), .boot_err_o(err2),
        .fetch_en_o(fetch2), .words_copied_o(copied2)
    );

    always @(posedge clk) if (rom_en2) rdata2 <= 32'hDEADBEEF ^ {22'b0, rom_addr2};

    int          nw2 = 0;
    logic [31:0] wa2, wd2;
    logic [3:0]  wb2;
    always @(posedge clk) if (req2 && gnt2) begin
        nw2 <= nw2 + 1;
        wa2 <= addr2;
        wd2 <= wdata2;
        wb2 <= be2;
    end

    // DUT3: default parameters
    logic        rst3_n, gnt3, restart3;
    logic        rom_en3, req3, we3, done3, err3, fetch3;
    logic [9:0]  rom_addr3;
    logic [31:0] rdata3, addr3, wdata3;
    logic [3:0]  be3;
    logic [10:0] copied3;

    boot_copy_ctrl u_dut3 (
        .clk_i(clk), .rst_n_i(rst3_n),
        .rom_en_o(rom_en3), .rom_addr_o(rom_addr3), .rom_rdata_i(rdata3),
        .ram_req_o(req3), .ram_we_o(we3), .ram_addr_o(addr3),
        .ram_wdata_o(wdata3), .ram_be_o(be3), .ram_gnt_i(gnt3),
        .restart_i(restart3), .boot_done_o(done3), .boot_err_o(err3),
        .fetch_en_o(fetch3), .words_copied_o(copied3)
    );

    always @(posedge clk) if (rom_en3) rdata3 <= 32'h5A5A0000 ^ {22'b0, rom_addr3};

    int          nw3 = 0;
    logic [31:0] la3, ld3;
    always @(posedge clk) if (req3 && gnt3) begin
        nw3 <= nw3 + 1;
        la3 <= addr3;
        ld3 <= wdata3;
    end

    // Drives DUT1 gnt from a per-word stall table; returns done/err edge.
    task automatic run1(input int st[4], input bit gout, input int rs_at,
                        input int maxe, output int de, output int ee);
        int w, wc;
        bit pr, pg;
        w = 0; wc = 0; pr = 0; pg = 0; de = -1; ee = -1;
        for (int e = 1; e <= maxe; e++) begin
            @(posedge clk); #1;
            restart1 = (e == rs_at);
            if (pr && pg) begin
                w++;
                wc = 0;
            end else if (pr) begin
                wc++;
            end
            if (done1 && de < 0) de = e;
            if (err1 && ee < 0) ee = e;
            if (de >= 0 || ee >= 0) break;
            pr = req1;
            pg = req1 ? (wc >= st[(w < 4) ? w : 3]) : gout;
            gnt1 = pg;
        end
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({rom_en1, req1, we1, done1, err1, fetch1} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {rom_en1, req1, we1, done1, err1, fetch1});
        end
        total++;
        if ({rom_addr1, addr1, wdata1, be1} !== 78'b0) begin
            bad++;
            $display("FAIL reset_bus: got %h want 0",
                     {rom_addr1, addr1, wdata1, be1});
        end
        total++;
        if (copied1 !== 11'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d want 0", copied1);
        end
        total++;
        if ({done2, done3, req2, req3} !== 4'b0) begin
            bad++;
            $display("FAIL reset_other: got %b want 0000",
                     {done2, done3, req2, req3});
        end
    endtask

    task automatic test_copy;
        int base, nre, de, ee;
        @(negedge clk);
        base = nw1; nre = nre1;
        gnt1 = 1'b1;
        rst1_n = 1'b1;
        run1('{0, 0, 0, 0}, 1'b1, 0, 40, de, ee);
        total++;
        if (de !== 13) begin
            bad++;
            $display("FAIL copy_done_edge: got %0d want 13", de);
        end
        total++;
        if (nw1 - base !== 4) begin
            bad++;
            $display("FAIL copy_nwrites: got %0d want 4", nw1 - base);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({wa1[base+k], wd1[base+k], wb1[base+k]} !==
                {32'(4 * k), 32'hA0 + 32'(k), 4'hF}) begin
                bad++;
                $display("FAIL copy_word%0d: got %h/%h/%h want %h/%h/f", k,
                         wa1[base+k], wd1[base+k], wb1[base+k], 4 * k, 32'hA0 + k);
            end
        end
        total++;
        if (nre1 - nre !== 4) begin
            bad++;
            $display("FAIL copy_rom_en: got %0d want 4", nre1 - nre);
        end
        total++;
        if ({fetch1, err1, copied1} !== {1'b1, 1'b0, 11'd4}) begin
            bad++;
            $display("FAIL copy_status: got %b/%b/%0d want 1/0/4",
                     fetch1, err1, copied1);
        end
    endtask

    task automatic test_restart_done;
        int base, de, ee;
        base = nw1;
        restart1 = 1'b1;
        @(posedge clk); #1;
        restart1 = 1'b0;
        total++;
        if ({done1, fetch1, copied1, rom_en1, rom_addr1} !=
            {1'b0, 1'b0, 11'd0, 1'b1, 10'd0}) begin
            bad++;
            $display("FAIL restart_first: got %b/%b/%0d/%b/%0d want 0/0/0/1/0",
                     done1, fetch1, copied1, rom_en1, rom_addr1);
        end
        run1('{0, 0, 0, 0}, 1'b1, 0, 40, de, ee);
        total++;
        if (de !== 12) begin
            bad++;
            $display("FAIL restart_done_edge: got %0d want 12", de);
        end
        total++;
        if ({nw1 - base, wa1[base], wd1[base], copied1} !==
            {32'd4, 32'h0, 32'hA0, 11'd4}) begin
            bad++;
            $display("FAIL restart_recopy: got %0d/%h/%h/%0d want 4/0/a0/4",
                     nw1 - base, wa1[base], wd1[base], copied1);
        end
    endtask

    task automatic test_restart_ignored;
        int base, de, ee;
        base = nw1;
        restart1 = 1'b1;
        run1('{0, 0, 0, 0}, 1'b1, 5, 40, de, ee);
        total++;
        if (de !== 13) begin
            bad++;
            $display("FAIL ignored_done_edge: got %0d want 13", de);
        end
        total++;
        if ({nw1 - base, wa1[base+3], wd1[base+3], copied1} !==
            {32'd4, 32'hC, 32'hA3, 11'd4}) begin
            bad++;
            $display("FAIL ignored_copy: got %0d/%h/%h/%0d want 4/c/a3/4",
                     nw1 - base, wa1[base+3], wd1[base+3], copied1);
        end
    endtask

    task automatic test_stalls;
        int base, st0, sb0, de, ee;
        base = nw1; st0 = nst1; sb0 = stab1;
        restart1 = 1'b1;
        run1('{2, 0, 5, 3}, 1'b1, 0, 60, de, ee);
        total++;
        if (de !== 23) begin
            bad++;
            $display("FAIL stall_done_edge: got %0d want 23", de);
        end
        total++;
        if (nst1 - st0 !== 10) begin
            bad++;
            $display("FAIL stall_cycles: got %0d want 10", nst1 - st0);
        end
        total++;
        if (stab1 - sb0 !== 0) begin
            bad++;
            $display("FAIL stall_stable: got %0d changes want 0", stab1 - sb0);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({wa1[base+k], wd1[base+k]} !== {32'(4 * k), 32'hA0 + 32'(k)}) begin
                bad++;
                $display("FAIL stall_word%0d: got %h/%h want %h/%h", k,
                         wa1[base+k], wd1[base+k], 4 * k, 32'hA0 + k);
            end
        end
        total++;
        if ({err1, copied1} !== {1'b0, 11'd4}) begin
            bad++;
            $display("FAIL stall_status: got %b/%0d want 0/4", err1, copied1);
        end
    endtask

    task automatic test_timeout;
        int base, de, ee;
        base = nw1;
        restart1 = 1'b1;
        gnt1 = 1'b0;
        run1('{99, 99, 99, 99}, 1'b0, 0, 40, de, ee);
        total++;
        if (ee !== 11 || de !== -1) begin
            bad++;
            $display("FAIL timeout_edge: got err=%0d done=%0d want 11/-1", ee, de);
        end
        total++;
        if ({err1, fetch1, req1, done1, copied1} !== {4'b1000, 11'd0}) begin
            bad++;
            $display("FAIL timeout_status: got %b%b%b%b/%0d want 1000/0",
                     err1, fetch1, req1, done1, copied1);
        end
        total++;
        if (nw1 - base !== 0) begin
            bad++;
            $display("FAIL timeout_writes: got %0d want 0", nw1 - base);
        end
        restart1 = 1'b1;
        gnt1 = 1'b1;
        @(posedge clk); #1;
        restart1 = 1'b0;
        total++;
        if ({err1, rom_en1} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_restart: got err=%b rom_en=%b want 0/1",
                     err1, rom_en1);
        end
        run1('{0, 0, 0, 0}, 1'b1, 0, 40, de, ee);
        total++;
        if ({de, ee, err1, copied1} !== {32'd12, -32'sd1, 1'b0, 11'd4}) begin
            bad++;
            $display("FAIL timeout_recover: got %0d/%0d/%b/%0d want 12/-1/0/4",
                     de, ee, err1, copied1);
        end
    endtask

    task automatic test_timeout_edge;
        int de, ee;
        restart1 = 1'b1;
        run1('{7, 0, 0, 0}, 1'b1, 0, 60, de, ee);
        total++;
        if ({de, ee, err1, copied1} !== {32'd20, -32'sd1, 1'b0, 11'd4}) begin
            bad++;
            $display("FAIL expiry_grant: got %0d/%0d/%b/%0d want 20/-1/0/4",
                     de, ee, err1, copied1);
        end
    endtask

    task automatic test_reset_mid;
        int base, e, de, ee;
        restart1 = 1'b1;
        e = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            restart1 = 1'b0;
            e++;
            if (rom_en1 && rom_addr1 == 10'd2) break;
        end
        total++;
        if (e !== 7) begin
            bad++;
            $display("FAIL midrst_word2_edge: got %0d want 7", e);
        end
        #3 rst1_n = 1'b0;
        #1;
        total++;
        if ({rom_en1, req1, done1, fetch1, err1, rom_addr1, copied1} !== 26'b0) begin
            bad++;
            $display("FAIL midrst_outputs: got %b%b%b%b%b/%0d/%0d want 0",
                     rom_en1, req1, done1, fetch1, err1, rom_addr1, copied1);
        end
        @(negedge clk);
        base = nw1;
        rst1_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rom_en1, rom_addr1} !== {1'b1, 10'd0}) begin
            bad++;
            $display("FAIL midrst_rom0: got %b/%0d want 1/0", rom_en1, rom_addr1);
        end
        run1('{0, 0, 0, 0}, 1'b1, 0, 40, de, ee);
        total++;
        if ({de, nw1 - base, wa1[base], wd1[base], copied1} !==
            {32'd12, 32'd4, 32'h0, 32'hA0, 11'd4}) begin
            bad++;
            $display("FAIL midrst_recopy: got %0d/%0d/%h/%h/%0d want 12/4/0/a0/4",
                     de, nw1 - base, wa1[base], wd1[base], copied1);
        end
    endtask

    task automatic test_single;
        int de;
        de = -1;
        @(negedge clk);
        rst2_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (done2 && de < 0) de = e;
        end
        total++;
        if (de !== 4) begin
            bad++;
            $display("FAIL single_done_edge: got %0d want 4", de);
        end
        total++;
        if ({nw2, wa2, wd2, wb2} !== {32'd1, 32'h8000, 32'hDEADBEEF, 4'hF}) begin
            bad++;
            $display("FAIL single_write: got %0d/%h/%h/%h want 1/8000/deadbeef/f",
                     nw2, wa2, wd2, wb2);
        end
        total++;
        if ({copied2, fetch2, err2} !== {11'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL single_status: got %0d/%b/%b want 1/1/0",
                     copied2, fetch2, err2);
        end
    endtask

    task automatic test_latency;
        int de;
        de = -1;
        @(negedge clk);
        rst3_n = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk); #1;
            if (done3 && de < 0) de = e;
        end
        total++;
        if (de !== 175) begin
            bad++;
            $display("FAIL latency_done_edge: got %0d want 175", de);
        end
        total++;
        if ({nw3, la3, ld3, copied3} !== {32'd58, 32'd228, 32'h5A5A0039, 11'd58}) begin
            bad++;
            $display("FAIL latency_copy: got %0d/%h/%h/%0d want 58/e4/5a5a0039/58",
                     nw3, la3, ld3, copied3);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst1_n = 1'b0; rst2_n = 1'b0; rst3_n = 1'b0;
        gnt1 = 1'b0; restart1 = 1'b0;
        gnt2 = 1'b1; restart2 = 1'b0;
        gnt3 = 1'b1; restart3 = 1'b0;
        test_reset;
        test_copy;
        test_restart_done;
        test_restart_ignored;
        test_stalls;
        test_timeout;
        test_timeout_edge;
        test_reset_mid;
        test_single;
        test_latency;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
